// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C requester arbiter: controller states,
// I2C byte-master field widths and a small index helper.
package i2c_arb_pkg;

    // Field widths of the shared I2C byte master
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    // Controller states; the encoding is fixed so it can be probed and
    // compared against other tooling that decodes the state register.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LAUNCH     = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DONE  = 3'd3,
        RESP       = 3'd4
    } arb_state_t;

    // Index that follows idx in a ring of n slots (n-1 wraps to 0)
    function automatic int nextIndex(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at
// or after the pointer position, wrapping around the requester ring.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_idx,
    output logic            o_valid
);

    logic [PW-1:0] w_cand;

    // Walk the ring starting at the pointer and stop at the first request
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = PW'((int'(i_ptr) + k) % NREQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C byte master between NREQ clients.
// Latches the winning command, pulses the master enable, follows the
// ready busy/idle handshake and reports done/err back to the owner.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int EN_CYCLES = 5,
    parameter int TIMEOUT   = 1024,
    parameter int TW        = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [ADDR_W*NREQ-1:0]   req_addr,
    input  logic [DATA_W*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]          req_rw,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          done,
    output logic                     err,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [DATA_W-1:0]        m_data_in,
    output logic                     m_rw,
    output logic                     m_enable,
    input  logic                     m_ready,
    input  logic [DATA_W-1:0]        m_data_out
);

    localparam int PW  = $clog2(NREQ);
    localparam int ENW = $clog2(EN_CYCLES + 1);

    localparam logic [ENW-1:0] EN_LAST   = ENW'(EN_CYCLES - 1);
    localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT);

    arb_state_t        r_state;
    logic [PW-1:0]     r_ptr;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_mAddr;
    logic [DATA_W-1:0] r_mData;
    logic              r_mRw;
    logic              r_mEnable;
    logic [ENW-1:0]    r_enCnt;
    logic [TW-1:0]     r_timer;

    logic [NREQ-1:0]   w_winGrant;
    logic [PW-1:0]     w_winIdx;
    logic              w_winValid;
    logic [ADDR_W-1:0] w_selAddr;
    logic [DATA_W-1:0] w_selData;
    logic              w_selRw;
    logic              w_timerMax;
    logic              w_canStart;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_winGrant),
        .o_idx   (w_winIdx),
        .o_valid (w_winValid)
    );

    // Route the winning requester's command fields toward the latch
    always_comb begin
        w_selAddr = '0;
        w_selData = '0;
        w_selRw   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winGrant[i]) begin
                w_selAddr = req_addr[i*ADDR_W +: ADDR_W];
                w_selData = req_data[i*DATA_W +: DATA_W];
                w_selRw   = req_rw[i];
            end
        end
    end

    assign w_timerMax = (r_timer == TIMER_MAX);
    assign w_canStart = w_winValid && m_ready;

    // Transaction controller: arbitration, launch, handshake tracking, response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_mAddr   <= '0;
            r_mData   <= '0;
            r_mRw     <= 1'b0;
            r_mEnable <= 1'b0;
            r_enCnt   <= '0;
            r_timer   <= '0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_canStart) begin
                        r_grant   <= w_winGrant;
                        r_mAddr   <= w_selAddr;
                        r_mData   <= w_selData;
                        r_mRw     <= w_selRw;
                        r_ptr     <= PW'(nextIndex(int'(w_winIdx), NREQ));
                        r_mEnable <= 1'b1;
                        r_enCnt   <= '0;
                        r_timer   <= '0;
                        r_state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (!m_ready) begin
                        r_mEnable <= 1'b0;
                        r_timer   <= '0;
                        r_state   <= WAIT_DONE;
                    end else if (r_enCnt == EN_LAST) begin
                        r_mEnable <= 1'b0;
                        r_timer   <= '0;
                        r_state   <= WAIT_START;
                    end else begin
                        r_enCnt <= r_enCnt + 1'b1;
                    end
                end
                WAIT_START: begin
                    if (!m_ready) begin
                        r_timer <= '0;
                        r_state <= WAIT_DONE;
                    end else if (w_timerMax) begin
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (m_ready) begin
                        if (r_mRw) begin
                            r_rdata <= m_data_out;
                        end
                        r_done  <= r_grant;
                        r_state <= RESP;
                    end else if (w_timerMax) begin
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RESP: begin
                    r_grant <= '0;
                    r_timer <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_grant   <= '0;
                    r_mEnable <= 1'b0;
                    r_timer   <= '0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign busy      = (r_state != IDLE);
    assign m_addr    = r_mAddr;
    assign m_data_in = r_mData;
    assign m_rw      = r_mRw;
    assign m_enable  = r_mEnable;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter: behavioural I2C master model,
// table-driven single transactions, hand-written corner sequences and a
// randomized multi-requester run against a transaction-level model.
module tb_i2c_req_arbiter;
    import i2c_arb_pkg::*;

    localparam int NREQ      = 4;
    localparam int EN_CYCLES = 5;
    localparam int TIMEOUT   = 1024;
    localparam int TW        = 11;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [7*NREQ-1:0]      reqAddr;
    logic [8*NREQ-1:0]      reqData;
    logic [NREQ-1:0]        reqRw;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        done;
    logic                   err;
    logic [7:0]             rdata;
    logic                   busy;
    logic [6:0]             mAddr;
    logic [7:0]             mDataIn;
    logic                   mRw;
    logic                   mEnable;
    logic                   mReady;
    logic [7:0]             mDataOut = 8'h00;

    always #5 clk = ~clk;

    i2c_req_arbiter #(
        .NREQ      (NREQ),
        .EN_CYCLES (EN_CYCLES),
        .TIMEOUT   (TIMEOUT),
        .TW        (TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_addr   (reqAddr),
        .req_data   (reqData),
        .req_rw     (reqRw),
        .grant      (grant),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .busy       (busy),
        .m_addr     (mAddr),
        .m_data_in  (mDataIn),
        .m_rw       (mRw),
        .m_enable   (mEnable),
        .m_ready    (mReady),
        .m_data_out (mDataOut)
    );

    // Behavioural I2C master: goes busy either mDelay cycles after enable
    // falls, or early after mEarly enable cycles; stays busy mBusy cycles.
    logic       mReadyModel = 1'b1;
    logic       mForce      = 1'b0;
    int         mDelay      = 2;
    int         mBusy       = 3;
    int         mEarly      = 0;
    int         mNoStart    = 0;
    logic [7:0] mByte       = 8'h00;
    int         mPhase      = 0;
    int         mCnt        = 0;

    assign mReady = mForce ? 1'b0 : mReadyModel;

    always @(posedge clk) begin
        case (mPhase)
            0: if (mEnable && mNoStart == 0) begin
                   mCnt <= 1;
                   if (mEarly == 1) begin
                       mReadyModel <= 1'b0;
                       mPhase      <= 3;
                   end else begin
                       mPhase <= 1;
                   end
               end
            1: if (mEnable) begin
                   if (mEarly != 0 && mCnt + 1 == mEarly) begin
                       mReadyModel <= 1'b0;
                       mPhase      <= 3;
                       mCnt        <= 1;
                   end else begin
                       mCnt <= mCnt + 1;
                   end
               end else if (mDelay == 0) begin
                   mReadyModel <= 1'b0;
                   mPhase      <= 3;
                   mCnt        <= 1;
               end else begin
                   mPhase <= 2;
                   mCnt   <= 1;
               end
            2: if (mCnt >= mDelay) begin
                   mReadyModel <= 1'b0;
                   mPhase      <= 3;
                   mCnt        <= 1;
               end else begin
                   mCnt <= mCnt + 1;
               end
            default: if (mCnt >= mBusy) begin
                   mReadyModel <= 1'b1;
                   mDataOut    <= mByte;
                   mPhase      <= 0;
               end else begin
                   mCnt <= mCnt + 1;
               end
        endcase
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         idx;
        logic [6:0] addr;
        logic [7:0] data;
        logic       rw;
        logic [7:0] rbyte;
        int         delay;
        int         early;
        int         expEn;
        logic [7:0] expRdata;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic setReq(input int i, input logic [6:0] a, input logic [7:0] d, input logic rw);
        reqAddr[i*ADDR_W +: ADDR_W] = a;
        reqData[i*DATA_W +: DATA_W] = d;
        reqRw[i] = rw;
        req[i]   = 1'b1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        req   = '0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic waitGrant(input int budget);
        int cyc;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (grant == '0 && cyc < budget);
    endtask

    task automatic waitResp(input int budget);
        int cyc;
        cyc = 0;
        while (done == '0 && err == 1'b0 && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    // Spec rule: first asserted requester in priority order ptr, ptr+1, ...
    function automatic int pickRR(input logic [NREQ-1:0] r, input int p);
        int order[$];
        for (int k = 0; k < NREQ; k++) order.push_back((p + k) % NREQ);
        foreach (order[j]) if (r[order[j]]) return order[j];
        return -1;
    endfunction

    task automatic applyStimulus(input vec_t v, input int n);
        int cyc;
        int enCount;
        mDelay = v.delay;
        mBusy  = 3;
        mEarly = v.early;
        mByte  = v.rbyte;
        setReq(v.idx, v.addr, v.data, v.rw);
        waitGrant(50);
        checkOutput($sformatf("v%0d grant", n), grant, 1 << v.idx);
        checkOutput($sformatf("v%0d m_addr", n), mAddr, v.addr);
        checkOutput($sformatf("v%0d m_data_in", n), mDataIn, v.data);
        checkOutput($sformatf("v%0d m_rw", n), mRw, v.rw);
        enCount = 0;
        cyc = 0;
        while (done == '0 && err == 1'b0 && cyc < 200) begin
            if (mEnable) enCount++;
            tick();
            cyc++;
        end
        checkOutput($sformatf("v%0d done", n), done, 1 << v.idx);
        checkOutput($sformatf("v%0d err", n), err, 0);
        checkOutput($sformatf("v%0d rdata", n), rdata, v.expRdata);
        checkOutput($sformatf("v%0d enable cycles", n), enCount, v.expEn);
        checkOutput($sformatf("v%0d m_addr stable", n), mAddr, v.addr);
        req[v.idx] = 1'b0;
        repeat (10) tick();
        checkOutput($sformatf("v%0d rdata held", n), rdata, v.expRdata);
        checkOutput($sformatf("v%0d idle grant", n), grant, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        int cnt;
        int gcount;
        int doneCnt;
        logic [6:0] cmdAddr[NREQ];
        logic [7:0] cmdData[NREQ];
        logic       cmdRw[NREQ];
        int         ptr;
        int         owner;
        int         w;
        int         age;
        int         maxAge;
        logic       inTx;
        logic       clearNext;
        logic       idlePrev;
        logic [NREQ-1:0] reqS;
        logic [NREQ-1:0] lvl;
        logic       readyS;
        logic [6:0] expAddr;
        logic [7:0] expData;
        logic       expRw;
        logic [7:0] expByte;
        logic [7:0] lastRead;

        vecs[0] = '{0, 7'h2A, 8'hAA, 1'b0, 8'h00, 3, 0, 5, 8'h00};
        vecs[1] = '{2, 7'h2A, 8'h00, 1'b1, 8'h5C, 2, 0, 5, 8'h5C};
        vecs[2] = '{1, 7'h7F, 8'h00, 1'b0, 8'h00, 0, 2, 3, 8'h5C};
        vecs[3] = '{3, 7'h00, 8'hFF, 1'b1, 8'hA5, 1, 1, 2, 8'hA5};
        vecs[4] = '{1, 7'h15, 8'h3C, 1'b1, 8'h3C, 4, 0, 5, 8'h3C};

        reset   = 1'b0;
        req     = '0;
        reqAddr = '0;
        reqData = '0;
        reqRw   = '0;

        // Reset state
        repeat (2) tick();
        checkOutput("reset grant", grant, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset rdata", rdata, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset m_enable", mEnable, 0);
        checkOutput("reset m_fields", {mAddr, mDataIn, mRw}, 0);
        reset = 1'b1;
        tick();

        // Timeout: master never goes busy
        mNoStart = 1;
        setReq(0, 7'h11, 8'h22, 1'b0);
        waitGrant(20);
        checkOutput("timeout grant", grant, 1);
        cyc = 0;
        doneCnt = 0;
        while (err == 1'b0 && cyc < TIMEOUT + 100) begin
            tick();
            cyc++;
            if (done != '0) doneCnt++;
        end
        checkOutput("timeout latency", cyc, TIMEOUT + EN_CYCLES + 1);
        checkOutput("timeout err", err, 1);
        checkOutput("timeout done", doneCnt, 0);
        req[0] = 1'b0;
        mNoStart = 0;
        tick();
        checkOutput("timeout err one cycle", err, 0);
        repeat (2) tick();

        // Table-driven single transactions (first one follows the timeout)
        for (int n = 0; n < 5; n++) applyStimulus(vecs[n], n);

        // Contention: all four held high, strict rotation from pointer 0
        doReset();
        for (int i = 0; i < NREQ; i++) begin
            cmdAddr[i] = 7'(8'h10 + i);
            setReq(i, cmdAddr[i], 8'(i * 17), 1'(i % 2));
        end
        mDelay = 1;
        mBusy  = 2;
        mEarly = 0;
        mByte  = 8'h77;
        for (int n = 0; n < 5; n++) begin
            waitGrant(50);
            checkOutput($sformatf("contention grant %0d", n), grant, 1 << (n % NREQ));
            waitResp(100);
            checkOutput($sformatf("contention done %0d", n), done, 1 << (n % NREQ));
            if (n == 4) req = '0;
            tick();
        end
        repeat (3) tick();

        // Master busy when the request arrives
        mForce = 1'b1;
        mDelay = 2;
        setReq(1, 7'h33, 8'h44, 1'b0);
        gcount = 0;
        repeat (6) begin
            tick();
            if (grant != '0) gcount++;
        end
        checkOutput("busy master no grant", gcount, 0);
        mForce = 1'b0;
        tick();
        checkOutput("busy master grant", grant, 4'b0010);
        waitResp(100);
        checkOutput("busy master done", done, 4'b0010);
        req[1] = 1'b0;
        repeat (3) tick();

        // Reset during a long read, with requester 3 queued
        mDelay = 1;
        mBusy  = 60;
        mEarly = 0;
        mByte  = 8'hC3;
        setReq(2, 7'h2A, 8'h00, 1'b1);
        waitGrant(50);
        cyc = 0;
        while (!(mEnable == 1'b0 && mReady == 1'b0) && cyc < 30) begin
            tick();
            cyc++;
        end
        checkOutput("mid-read in progress", busy, 1);
        setReq(3, 7'h55, 8'h66, 1'b0);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid-read reset grant", grant, 0);
        checkOutput("mid-read reset m_enable", mEnable, 0);
        checkOutput("mid-read reset busy", busy, 0);
        req[2] = 1'b0;
        tick();
        reset = 1'b1;
        cnt = 0;
        gcount = 0;
        while (mReady == 1'b0 && cnt < 200) begin
            if (grant != '0) gcount++;
            tick();
            cnt++;
        end
        checkOutput("post-reset no grant while busy", gcount, 0);
        checkOutput("post-reset grant before sample", grant, 0);
        mBusy = 3;
        tick();
        checkOutput("post-reset grant", grant, 4'b1000);
        waitResp(100);
        checkOutput("post-reset done", done, 4'b1000);
        checkOutput("post-reset rdata", rdata, 0);
        req[3] = 1'b0;
        repeat (3) tick();

        // Randomized traffic against a transaction-level model
        doReset();
        ptr       = 0;
        owner     = 0;
        inTx      = 1'b0;
        clearNext = 1'b0;
        lastRead  = 8'h00;
        age       = 0;
        maxAge    = 0;
        expAddr   = '0;
        expData   = '0;
        expRw     = 1'b0;
        expByte   = '0;
        reqS      = req;
        readyS    = mReady;
        for (int c = 0; c < 3000; c++) begin
            tick();
            lvl = req;
            idlePrev = !inTx;
            if (clearNext) begin
                inTx = 1'b0;
                clearNext = 1'b0;
            end
            if (idlePrev && reqS != '0 && readyS) begin
                w = pickRR(reqS, ptr);
                owner = w;
                ptr = (w + 1) % NREQ;
                inTx = 1'b1;
                age = 0;
                expAddr = cmdAddr[w];
                expData = cmdData[w];
                expRw   = cmdRw[w];
                mDelay = $urandom_range(0, 4);
                mBusy  = $urandom_range(1, 6);
                mEarly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                mByte  = 8'($urandom_range(0, 255));
                expByte = mByte;
            end
            checkOutput("rand busy", busy, inTx);
            checkOutput("rand grant", grant, inTx ? (1 << owner) : 0);
            if (inTx) begin
                age++;
                if (age > maxAge) maxAge = age;
                checkOutput("rand m_fields", {mAddr, mDataIn, mRw}, {expAddr, expData, expRw});
            end
            if (done != '0 || err) begin
                checkOutput("rand err", err, 0);
                checkOutput("rand done", done, 1 << owner);
                if (expRw) lastRead = expByte;
                checkOutput("rand rdata", rdata, lastRead);
                if ($urandom_range(0, 3) != 0) req[owner] = 1'b0;
                clearNext = 1'b1;
            end else if (inTx && $urandom_range(0, 63) == 0) begin
                req[owner] = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!lvl[i] && $urandom_range(0, 3) == 0) begin
                    cmdAddr[i] = 7'($urandom_range(0, 127));
                    cmdData[i] = 8'($urandom_range(0, 255));
                    cmdRw[i]   = 1'($urandom_range(0, 1));
                    setReq(i, cmdAddr[i], cmdData[i], cmdRw[i]);
                end
            end
            reqS   = req;
            readyS = mReady;
        end
        checkOutput("rand transaction length bounded", maxAge <= 100, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
